// File: rtl/display_ctrl_if.sv
// rtl/display_ctrl_if.sv - keycode/tick input and pose output bundle for display_ctrl
// master drives keycode and frame tick; slave (display_ctrl) returns the pose.
interface display_ctrl_if #(
   parameter int WI = 8,
   parameter int WF = 8
);
   logic                    frame_clk_rising_edge;
   logic [7:0]              keycode;
   logic [11:0]             alpha;
   logic [11:0]             beta;
   logic [11:0]             gamma;
   logic signed [WI+WF-1:0] x;
   logic signed [WI+WF-1:0] y;
   logic signed [WI+WF-1:0] z;

   modport master (
      output frame_clk_rising_edge, keycode,
      input  alpha, beta, gamma, x, y, z
   );

   modport slave (
      input  frame_clk_rising_edge, keycode,
      output alpha, beta, gamma, x, y, z
   );
endinterface

// File: rtl/display_ctrl.sv
// rtl/display_ctrl.sv - keyboard-driven pose integrator (angles with inertia, saturating position)
// Optional macro DISPLAY_DAMPING_EN: with no key held, angular velocity decays toward 0.
module display_ctrl #(
   parameter int WI   = 8,
   parameter int WF   = 8,
   parameter int VMAX = 16,
   parameter int ACC  = 1,
   parameter int STEP = 16,
   parameter int Z0   = 4 << WF
) (
   input  logic         Clk,
   input  logic         Reset,
   display_ctrl_if.slave bus
);
   localparam int W = WI + WF;
   localparam logic signed [11:0] TWO_PI = 12'sh648;
   localparam logic signed [11:0] VMAX_S = 12'(VMAX);
   localparam logic signed [11:0] ACC_S  = 12'(ACC);
   localparam logic signed [W:0]  STEP_S = (W+1)'(STEP);
   localparam logic signed [W:0]  P_MAX  = {2'b00, {(W-1){1'b1}}};
   localparam logic signed [W:0]  P_MIN  = {2'b11, {(W-1){1'b0}}};

   logic [11:0]        ang_q [3];
   logic [11:0]        ang_d [3];
   logic signed [11:0] vel_q [3];
   logic signed [11:0] vel_d [3];
   logic signed [W-1:0] pos_q [3];
   logic signed [W-1:0] pos_d [3];

   logic [2:0] rot_up, rot_dn, pos_up, pos_dn;

   function automatic logic signed [11:0] vel_next(input logic signed [11:0] v,
                                                  input logic u, input logic d);
      logic signed [11:0] r;
      r = v;
      if (u)
         r = (v + ACC_S > VMAX_S) ? VMAX_S : v + ACC_S;
      else if (d)
         r = (v - ACC_S < -VMAX_S) ? -VMAX_S : v - ACC_S;
`ifdef DISPLAY_DAMPING_EN
      else if (v > ACC_S)
         r = v - ACC_S;
      else if (v < -ACC_S)
         r = v + ACC_S;
      else
         r = '0;
`else
      else
         r = v;
`endif
      return r;
   endfunction

   // Angles stay in [0, 2*pi); |v| < 2*pi so a single correction is enough.
   function automatic logic [11:0] ang_next(input logic [11:0] a, input logic signed [11:0] v);
      logic signed [11:0] s;
      s = $signed(a) + v;
      if (s < 12'sd0)
         s = s + TWO_PI;
      else if (s >= TWO_PI)
         s = s - TWO_PI;
      return $unsigned(s);
   endfunction

   function automatic logic signed [W-1:0] pos_next(input logic signed [W-1:0] p,
                                                   input logic u, input logic d);
      logic signed [W:0] s;
      s = {p[W-1], p};
      if (u)
         s = s + STEP_S;
      else if (d)
         s = s - STEP_S;
      if (s > P_MAX)
         s = P_MAX;
      else if (s < P_MIN)
         s = P_MIN;
      return s[W-1:0];
   endfunction

   always_comb begin
      rot_up = '0;
      rot_dn = '0;
      pos_up = '0;
      pos_dn = '0;
      case (bus.keycode)
         8'h14:   rot_up[0] = 1'b1;
         8'h08:   rot_dn[0] = 1'b1;
         8'h1A:   rot_up[1] = 1'b1;
         8'h16:   rot_dn[1] = 1'b1;
         8'h04:   rot_up[2] = 1'b1;
         8'h07:   rot_dn[2] = 1'b1;
         8'h0F:   pos_up[0] = 1'b1;
         8'h0D:   pos_dn[0] = 1'b1;
         8'h18:   pos_up[1] = 1'b1;
         8'h12:   pos_dn[1] = 1'b1;
         8'h0C:   pos_up[2] = 1'b1;
         8'h0E:   pos_dn[2] = 1'b1;
         default: ;
      endcase
   end

   // Angle integrates the pre-update velocity, giving one tick of latency from key to motion.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         ang_d[i] = ang_q[i];
         vel_d[i] = vel_q[i];
         pos_d[i] = pos_q[i];
         if (bus.frame_clk_rising_edge) begin
            ang_d[i] = ang_next(ang_q[i], vel_q[i]);
            vel_d[i] = vel_next(vel_q[i], rot_up[i], rot_dn[i]);
            pos_d[i] = pos_next(pos_q[i], pos_up[i], pos_dn[i]);
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < 3; i++) begin
            ang_q[i] <= '0;
            vel_q[i] <= '0;
         end
         pos_q[0] <= '0;
         pos_q[1] <= '0;
         pos_q[2] <= W'(Z0);
      end else begin
         for (int i = 0; i < 3; i++) begin
            ang_q[i] <= ang_d[i];
            vel_q[i] <= vel_d[i];
            pos_q[i] <= pos_d[i];
         end
      end
   end

   assign bus.alpha = ang_q[0];
   assign bus.beta  = ang_q[1];
   assign bus.gamma = ang_q[2];
   assign bus.x     = pos_q[0];
   assign bus.y     = pos_q[1];
   assign bus.z     = pos_q[2];
endmodule

// File: tb/tb_display_ctrl.sv
// tb/tb_display_ctrl.sv - directed vector bench for display_ctrl
module tb_display_ctrl;
   typedef struct {
      bit          rst;
      logic [7:0]  key;
      bit          tick;
      logic [11:0] a, b, g;
      logic [15:0] x, y, z;
   } vec_t;

   logic clk;
   logic rst_n;
   int   nvec;
   int   nerr;
   vec_t tbl[$];

   display_ctrl_if #(.WI(8), .WF(8)) bus ();

   display_ctrl #(.WI(8), .WF(8), .VMAX(16), .ACC(1), .STEP(16)) dut (
      .Clk  (clk),
      .Reset(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input bit rst, input int key, input bit tick,
                      input int a, input int b, input int g,
                      input int x, input int y, input int z);
      vec_t v;
      v.rst = rst; v.key = 8'(key); v.tick = tick;
      v.a = 12'(a); v.b = 12'(b); v.g = 12'(g);
      v.x = 16'(x); v.y = 16'(y); v.z = 16'(z);
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input int a, input int b, input int g,
                        input int x, input int y, input int z);
      nvec++;
      if (bus.alpha !== 12'(a) || bus.beta !== 12'(b) || bus.gamma !== 12'(g) ||
          bus.x !== 16'(x) || bus.y !== 16'(y) || bus.z !== 16'(z)) begin
         nerr++;
         $display("FAIL %s: got a=%h b=%h g=%h x=%h y=%h z=%h, want a=%h b=%h g=%h x=%h y=%h z=%h",
                  name, bus.alpha, bus.beta, bus.gamma, bus.x, bus.y, bus.z,
                  12'(a), 12'(b), 12'(g), 16'(x), 16'(y), 16'(z));
      end
   endtask

   task automatic step(input int key, input bit tick);
      bus.keycode = 8'(key);
      bus.frame_clk_rising_edge = tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(0, 1'b1);
      rst_n = 1'b1;
   endtask

   initial begin
      int ea, vd;
      nvec = 0;
      nerr = 0;
      rst_n = 1'b1;
      bus.keycode = 8'h00;
      bus.frame_clk_rising_edge = 1'b0;

      // Reset with a key and tick active, then idle ticks.
      add(1, 'h14, 1, 0, 0, 0, 0, 0, 'h400);
      for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 0, 0, 0, 0, 'h400);
      // Negative alpha: first tick only sets v, second wraps below zero.
      add(1, 0, 1, 0, 0, 0, 0, 0, 'h400);
      add(0, 'h08, 1, 0, 0, 0, 0, 0, 'h400);
      add(0, 'h08, 1, 'h647, 0, 0, 0, 0, 'h400);
      add(0, 'h08, 1, 'h645, 0, 0, 0, 0, 'h400);
      add(0, 'h08, 1, 'h642, 0, 0, 0, 0, 'h400);
      add(1, 0, 1, 0, 0, 0, 0, 0, 'h400);
      add(0, 'h1A, 1, 0, 0, 0, 0, 0, 'h400);
      add(0, 'h1A, 1, 0, 1, 0, 0, 0, 'h400);
      add(0, 'h1A, 1, 0, 3, 0, 0, 0, 'h400);
      add(1, 0, 1, 0, 0, 0, 0, 0, 'h400);
      add(0, 'h16, 1, 0, 0, 0, 0, 0, 'h400);
      add(0, 'h16, 1, 0, 'h647, 0, 0, 0, 'h400);
      add(1, 0, 1, 0, 0, 0, 0, 0, 'h400);
      add(0, 'h07, 1, 0, 0, 0, 0, 0, 'h400);
      add(0, 'h07, 1, 0, 0, 'h647, 0, 0, 'h400);
      add(0, 'h07, 1, 0, 0, 'h645, 0, 0, 'h400);
      add(1, 0, 1, 0, 0, 0, 0, 0, 'h400);
      add(0, 'h04, 1, 0, 0, 0, 0, 0, 'h400);
      add(0, 'h04, 1, 0, 0, 1, 0, 0, 'h400);
      add(0, 'h04, 1, 0, 0, 3, 0, 0, 'h400);
      // Translation, including held keys with the tick low.
      add(1, 0, 1, 0, 0, 0, 0, 0, 'h400);
      for (int k = 1; k <= 10; k++) add(0, 'h0C, 1, 0, 0, 0, 0, 0, 'h400 + 16 * k);
      for (int k = 0; k < 5; k++) add(0, 'h0C, 0, 0, 0, 0, 0, 0, 'h4A0);
      for (int k = 0; k < 2; k++) add(0, 'h14, 0, 0, 0, 0, 0, 0, 'h4A0);
      add(0, 'h0E, 1, 0, 0, 0, 0, 0, 'h490);
      add(0, 'h0E, 1, 0, 0, 0, 0, 0, 'h480);
      for (int k = 1; k <= 3; k++) add(0, 'h0F, 1, 0, 0, 0, 16 * k, 0, 'h480);
      for (int k = 1; k <= 4; k++) add(0, 'h0D, 1, 0, 0, 0, 48 - 16 * k, 0, 'h480);
      add(0, 'h18, 1, 0, 0, 0, -16, 16, 'h480);
      add(0, 'h18, 1, 0, 0, 0, -16, 32, 'h480);
      for (int k = 1; k <= 3; k++) add(0, 'h12, 1, 0, 0, 0, -16, 32 - 16 * k, 'h480);
      add(0, 'h05, 1, 0, 0, 0, -16, -16, 'h480);
      add(0, 'h05, 1, 0, 0, 0, -16, -16, 'h480);
      // Alpha ramp: velocity saturates at 16, so alpha is a triangular sum then linear.
      add(1, 0, 1, 0, 0, 0, 0, 0, 'h400);
      for (int n = 1; n <= 20; n++)
         add(0, 'h14, 1, (n <= 17) ? n * (n - 1) / 2 : 136 + 16 * (n - 17), 0, 0, 0, 0, 'h400);

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) rst_n = 1'b0;
         step(int'(tbl[i].key), tbl[i].tick);
         check($sformatf("vec[%0d]", i), int'(tbl[i].a), int'(tbl[i].b), int'(tbl[i].g),
               int'($signed(tbl[i].x)), int'($signed(tbl[i].y)), int'($signed(tbl[i].z)));
         rst_n = 1'b1;
      end

      // Keep spinning at v=16 through the 2*pi boundary (lands exactly on 0x648 once).
      ea = 184;
      for (int i = 0; i < 95; i++) begin
         step('h14, 1'b1);
         ea = ea + 16;
         if (ea >= 'h648) ea = ea - 'h648;
         check($sformatf("wrap[%0d]", i), ea, 0, 0, 0, 0, 'h400);
      end

      // Release the key.
      vd = 16;
      for (int i = 0; i < 20; i++) begin
         step(0, 1'b1);
         ea = ea + vd;
         if (ea >= 'h648) ea = ea - 'h648;
`ifdef DISPLAY_DAMPING_EN
         if (vd > 0) vd = vd - 1;
`endif
         check($sformatf("release[%0d]", i), ea, 0, 0, 0, 0, 'h400);
      end

      // Positive saturation on x: 2048 steps of 16 would reach 0x8000.
      do_reset();
      for (int i = 0; i < 2047; i++) step('h0F, 1'b1);
      check("x_presat", 0, 0, 0, 'h7FF0, 0, 'h400);
      step('h0F, 1'b1);
      check("x_sat", 0, 0, 0, 'h7FFF, 0, 'h400);
      step('h0F, 1'b1);
      check("x_sat_hold", 0, 0, 0, 'h7FFF, 0, 'h400);

      // Negative limit on y is exactly reachable, then must hold.
      do_reset();
      for (int i = 0; i < 2048; i++) step('h12, 1'b1);
      check("y_min", 0, 0, 0, 0, -32768, 'h400);
      step('h12, 1'b1);
      check("y_min_hold", 0, 0, 0, 0, -32768, 'h400);

      // Asynchronous reset in the middle of a ramp, away from any clock edge.
      do_reset();
      for (int i = 0; i < 5; i++) step('h14, 1'b1);
      check("pre_async", 10, 0, 0, 0, 0, 'h400);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst", 0, 0, 0, 0, 0, 'h400);
      rst_n = 1'b1;
      step(0, 1'b1);
      check("after_async", 0, 0, 0, 0, 0, 'h400);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/display_ctrl.md
Name: display_ctrl

Overview:
- Keyboard-driven pose controller for the FPGA 3D renderer; sits between the USB keyboard keycode register and the transform/projection pipeline.
- Once per frame tick it integrates three per-axis rotation angles, each with its own angular velocity, and three translation offsets.
- Outputs the pose as rotation angles alpha/beta/gamma and signed fixed-point position x/y/z.

Parameters:
- WI, 8, integer bits of the position outputs (signed, two's complement).
- WF, 8, fractional bits of the position outputs.
- VMAX, 16, maximum angular-velocity magnitude, in angle LSBs per tick.
- ACC, 1, angular-velocity change per tick.
- STEP, 16, position change per tick, in position LSBs (1/2^WF units).
- Z0, 4<<WF, reset value of z (object placed 4.0 units in front of the camera).

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-low reset (asserted when 0).
- frame_clk_rising_edge  in  1  one-cycle frame tick; state updates only when high.
- keycode  in  8  USB HID keycode of the held key; 0 means no key.
- alpha  out  12  x-axis rotation angle; unsigned, 0..0x647, LSB = 1/256 rad.
- beta  out  12  y-axis rotation angle; same format as alpha.
- gamma  out  12  z-axis rotation angle; same format as alpha.
- x  out  WI+WF  x translation, signed Q(WI).(WF).
- y  out  WI+WF  y translation, signed Q(WI).(WF).
- z  out  WI+WF  z translation, signed Q(WI).(WF).

Behaviour:
- Reset (asynchronous, Reset=0):
  - all angles and all angular velocities = 0;
  - x = y = 0, z = Z0.
- All outputs are direct register outputs. With no tick pending, outputs and internal state hold.
- Key map. A positive key drives velocity up; a negative key drives it down; any other keycode means no key for every axis.
  - alpha: 0x14 (Q) positive, 0x08 (E) negative.
  - beta: 0x1A (W) positive, 0x16 (S) negative.
  - gamma: 0x04 (A) positive, 0x07 (D) negative.
  - x translation: 0x0F (L) +STEP, 0x0D (J) -STEP.
  - y translation: 0x18 (U) +STEP, 0x12 (O) -STEP.
  - z translation: 0x0C (I) +STEP, 0x0E (K) -STEP.
- Per-axis angular velocity v: 12-bit signed, always within [-VMAX, +VMAX].
- On each tick, per rotation axis:
  - Positive key: v <= min(v+ACC, VMAX).
  - Negative key: v <= max(v-ACC, -VMAX).
  - No key: damping rule (see Optional Feature).
- Angle update, evaluated in the same tick using the pre-update v:
  - s = signed 12-bit (angle + v);
  - if s < 0, angle <= s + 0x648;
  - else if s >= 0x648, angle <= s - 0x648;
  - else angle <= s.
  - All comparisons are signed against 0x648 (2*pi = 1608 LSB).
  - One correction always suffices because |v| <= VMAX < 0x648.
- Latency: a key held from tick N changes v at tick N and the angle first moves at tick N+1.
- Position update per tick: p <= p ± STEP, saturating at the signed WI+WF range limits (no wrap).
- Only one keycode exists at a time, so no simultaneous-key cases arise.
- Reset asserted mid-ramp clears state immediately, independent of Clk.

Optional Feature:
- Macro: DISPLAY_DAMPING_EN.
- Defined: with no key, v moves toward 0 by ACC per tick, clamped at 0 (no overshoot), so rotation coasts to a stop.
- Undefined: with no key, v holds its value (pure inertia, perpetual spin).
- The opposite key is the only way to decelerate when undefined.

Test Plan:
- Reset=0 with keycode=0x14 and tick high: all angles 0, x=y=0, z=0x0400; Reset=1 then idle ticks keep these values.
- keycode=0x14, tick every cycle for 20 ticks:
  - alpha velocity reaches 16 at tick 16 and saturates;
  - alpha = 0xB8 (184) after tick 20.
- From reset, keycode=0x08:
  - after tick 1, v=-1 and alpha=0;
  - after tick 2, alpha=0x647 (negative wrap).
- Hold 0x14 until alpha is within 16 of 0x648, then continue: alpha wraps to (alpha+v-0x648) and never reads >= 0x648.
- With DISPLAY_DAMPING_EN, release to keycode=0 at v=16: v decrements 1 per tick to 0 in 16 ticks, then alpha is constant. Without the macro, v stays 16.
- Hold 0x0C for 10 ticks: z = 0x0400+0xA0 = 0x04A0. Drop frame_clk_rising_edge low for 5 cycles with a key held: no output changes.
